// File: rtl/ps2_device_emu.sv
// Device-side PS/2 engine: owns the PS/2 clock, sends bytes to the host,
// receives host commands with the ACK pulse and optionally answers 0xFA/0xFE.
module ps2_device_emu #(
    parameter int HALF_PER = 2000,
    parameter int RTS_MIN  = 500,
    parameter bit AUTO_ACK = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_ERR,
    input  logic       PS2CLK_I,
    input  logic       PS2DATA_I,
    output logic       PS2CLK_OE,
    output logic       PS2DATA_OE
);
    localparam int TMAX = (2 * HALF_PER > RTS_MIN) ? 2 * HALF_PER : RTS_MIN;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_HALF = TW'(HALF_PER - 1);
    localparam logic [TW-1:0] T_MID  = TW'(HALF_PER / 2);
    localparam logic [TW-1:0] T_FREE = TW'(2 * HALF_PER - 1);
    localparam logic [TW-1:0] T_RTS  = TW'(RTS_MIN - 1);

    typedef enum logic [3:0] {
        IDLE, TX_LOW, TX_HIGH, WAIT_FREE, RX_LOW, RX_HIGH, ACK_LOW, ACK_HIGH, HOLDOFF
    } state_t;

    state_t        state, state_n;
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic [TW-1:0] tmr, tmr_n;
    logic          tmr_done;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [10:0]   frame, frame_n;
    logic [9:0]    rx_sh, rx_sh_n;
    logic          ack_pend, ack_pend_n;
    logic [7:0]    ack_byte, ack_byte_n;
    logic [7:0]    rx_data_n;
    logic          rx_valid_n, rx_err_n, clk_oe_n, dat_oe_n;

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    assign clk_s    = clk_sync[1];
    assign dat_s    = dat_sync[1];
    assign tmr_done = (tmr == T_HALF);
    assign TX_READY = (state == IDLE) & clk_s & dat_s & ~ack_pend;

    always_comb begin
        state_n    = state;
        tmr_n      = tmr + TW'(1);
        bitcnt_n   = bitcnt;
        frame_n    = frame;
        rx_sh_n    = rx_sh;
        ack_pend_n = ack_pend;
        ack_byte_n = ack_byte;
        rx_data_n  = RX_DATA;
        rx_valid_n = 1'b0;
        rx_err_n   = 1'b0;
        case (state)
            IDLE: begin
                // tmr measures how long request-to-send has been held
                if (clk_s && !dat_s) begin
                    if (tmr == T_RTS) begin
                        state_n  = RX_LOW;
                        tmr_n    = '0;
                        bitcnt_n = '0;
                    end
                end else begin
                    tmr_n = '0;
                    if (clk_s && dat_s && (ack_pend || TX_VALID)) begin
                        frame_n    = ack_pend ? mk_frame(ack_byte) : mk_frame(TX_DATA);
                        ack_pend_n = 1'b0;
                        state_n    = TX_HIGH;
                        bitcnt_n   = '0;
                    end
                end
            end
            TX_HIGH: if (tmr_done) begin
                tmr_n   = '0;
                state_n = (!clk_s && bitcnt != 4'd10) ? WAIT_FREE : TX_LOW;
            end
            TX_LOW: if (tmr_done) begin
                tmr_n = '0;
                if (bitcnt == 4'd10) begin
                    state_n = HOLDOFF;
                end else begin
                    bitcnt_n = bitcnt + 4'd1;
                    state_n  = TX_HIGH;
                end
            end
            WAIT_FREE: begin
                if (!clk_s) begin
                    tmr_n = '0;
                end else if (tmr == T_FREE) begin
                    tmr_n    = '0;
                    bitcnt_n = '0;
                    state_n  = TX_HIGH;
                end
            end
            RX_LOW: if (tmr_done) begin
                tmr_n   = '0;
                state_n = RX_HIGH;
            end
            RX_HIGH: begin
                if (tmr == T_MID) rx_sh_n = {dat_s, rx_sh[9:1]};
                if (tmr_done) begin
                    tmr_n = '0;
                    if (bitcnt != 4'd9) begin
                        bitcnt_n = bitcnt + 4'd1;
                        state_n  = RX_LOW;
                    end else if (rx_sh_n[9]) begin
                        state_n = ACK_LOW;
                    end else begin
                        rx_err_n = 1'b1;
                        state_n  = HOLDOFF;
                    end
                end
            end
            ACK_LOW: if (tmr_done) begin
                tmr_n   = '0;
                state_n = ACK_HIGH;
            end
            ACK_HIGH: if (tmr_done) begin
                tmr_n      = '0;
                state_n    = HOLDOFF;
                rx_data_n  = rx_sh[7:0];
                rx_valid_n = ^rx_sh[8:0];
                rx_err_n   = ~^rx_sh[8:0];
            end
            HOLDOFF: if (tmr_done) begin
                tmr_n   = '0;
                state_n = IDLE;
            end
            default: begin
                tmr_n   = '0;
                state_n = IDLE;
            end
        endcase
        // a newer command result always replaces any unsent response
        if (AUTO_ACK && (rx_valid_n || rx_err_n)) begin
            ack_pend_n = 1'b1;
            ack_byte_n = rx_valid_n ? 8'hFA : 8'hFE;
        end
        clk_oe_n = state_n inside {TX_LOW, RX_LOW, ACK_LOW};
        dat_oe_n = ((state_n == TX_HIGH || state_n == TX_LOW) && !frame_n[bitcnt_n]) ||
                   (state_n inside {ACK_LOW, ACK_HIGH});
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clk_sync   <= '0;
            dat_sync   <= '0;
            state      <= IDLE;
            tmr        <= '0;
            bitcnt     <= '0;
            frame      <= '0;
            rx_sh      <= '0;
            ack_pend   <= 1'b0;
            ack_byte   <= '0;
            RX_DATA    <= '0;
            RX_VALID   <= 1'b0;
            RX_ERR     <= 1'b0;
            PS2CLK_OE  <= 1'b0;
            PS2DATA_OE <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], PS2CLK_I};
            dat_sync   <= {dat_sync[0], PS2DATA_I};
            state      <= state_n;
            tmr        <= tmr_n;
            bitcnt     <= bitcnt_n;
            frame      <= frame_n;
            rx_sh      <= rx_sh_n;
            ack_pend   <= ack_pend_n;
            ack_byte   <= ack_byte_n;
            RX_DATA    <= rx_data_n;
            RX_VALID   <= rx_valid_n;
            RX_ERR     <= rx_err_n;
            PS2CLK_OE  <= clk_oe_n;
            PS2DATA_OE <= dat_oe_n;
        end
    end
endmodule

// File: tb/tb_ps2_device_emu.sv
// Bench for ps2_device_emu: a host model drives the open-drain lines, frame and
// command monitors compare what the device does against expected-result queues.
module tb_ps2_device_emu;
    localparam int HP  = 4;
    localparam int RTS = 6;

    logic       CLK = 1'b0, RST = 1'b0;
    logic [7:0] TX_DATA = '0;
    logic       TX_VALID = 1'b0;
    logic       TX_READY, RX_VALID, RX_ERR, PS2CLK_OE, PS2DATA_OE;
    logic [7:0] RX_DATA;
    logic       host_clk_low = 1'b0, host_dat_low = 1'b0, host_busy = 1'b0;
    logic       ps2clk, ps2dat;

    assign ps2clk = ~PS2CLK_OE & ~host_clk_low;
    assign ps2dat = ~PS2DATA_OE & ~host_dat_low;

    always #5 CLK = ~CLK;

    ps2_device_emu #(.HALF_PER(HP), .RTS_MIN(RTS), .AUTO_ACK(1'b1)) dut (
        .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ERR(RX_ERR),
        .PS2CLK_I(ps2clk), .PS2DATA_I(ps2dat), .PS2CLK_OE(PS2CLK_OE), .PS2DATA_OE(PS2DATA_OE)
    );

    typedef struct { logic err; logic [7:0] data; } rx_exp_t;
    rx_exp_t    rxq[$];
    logic [7:0] txq[$];
    logic [7:0] last_rx = '0;
    int errs = 0, checks = 0, frames_done = 0, cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errs++;
        $display("FAIL %s", name);
    endtask

    // Device-to-host frame monitor: samples data on each falling clock edge.
    initial begin
        logic       prev = 1'b1, low_clean = 1'b0;
        logic [10:0] fb = '0;
        int nb = 0, last_fall = -1000, low_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RST || host_busy) begin
                nb = 0;
                low_clean = 1'b0;
            end else if (prev && !ps2clk) begin
                if (cyc - last_fall > 3 * HP) nb = 0;
                last_fall = cyc;
                fb[nb] = ps2dat;
                nb++;
                low_cnt = 1;
                low_clean = !host_clk_low;
                if (nb == 11) begin
                    nb = 0;
                    frames_done++;
                    check("frame_start", 32'(fb[0]), 0);
                    check("frame_stop", 32'(fb[10]), 1);
                    check("frame_parity", 32'(^fb[9:1]), 1);
                    if (txq.size() == 0) fail_now($sformatf("frame_unexpected got %02h", fb[8:1]));
                    else check("frame_byte", 32'(fb[8:1]), 32'(txq.pop_front()));
                end
            end else if (!ps2clk) begin
                low_cnt++;
                if (host_clk_low) low_clean = 1'b0;
            end else if (!prev && low_clean) begin
                check("clk_low_width", low_cnt, HP);
                low_clean = 1'b0;
            end
            prev = ps2clk;
        end
    end

    // Host-command result monitor.
    initial begin
        rx_exp_t e;
        forever begin
            @(negedge CLK);
            if (RST && (RX_VALID || RX_ERR)) begin
                if (rxq.size() == 0) fail_now("rx_unexpected_pulse");
                else begin
                    e = rxq.pop_front();
                    check("rx_flags", {30'd0, RX_VALID, RX_ERR}, {30'd0, !e.err, e.err});
                    check("rx_data", 32'(RX_DATA), 32'(e.data));
                end
            end
        end
    end

    task automatic wait_fall(output logic ok, output int n);
        logic prev;
        ok = 1'b0;
        n = 0;
        prev = ps2clk;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (prev && !ps2clk) begin ok = 1'b1; n = i + 1; break; end
            prev = ps2clk;
        end
        if (!ok) fail_now("wait_fall_timeout");
    endtask

    task automatic wait_rise(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (ps2clk) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("wait_rise_timeout");
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (TX_READY && txq.size() == 0 && rxq.size() == 0) begin ok = 1'b1; break; end
        end
        check("reach_idle", 32'(ok), 1);
    endtask

    task automatic tx_offer(input logic [7:0] b, output logic ok, output int fr);
        ok = 1'b0;
        fr = 0;
        @(negedge CLK);
        TX_DATA = b;
        TX_VALID = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (TX_READY) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
        if (ok) begin
            fr = frames_done;
            @(posedge CLK);
            #1 TX_VALID = 1'b0;
        end else begin
            TX_VALID = 1'b0;
        end
        check("tx_accepted", 32'(ok), 1);
    endtask

    // Host sends {stop, parity, data}; the device supplies every clock pulse.
    task automatic host_cmd(input logic [7:0] b, input logic par, input logic stop);
        logic [9:0] bits;
        logic ok;
        int n;
        bits = {stop, par, b};
        host_busy = 1'b1;
        @(negedge CLK);
        host_clk_low = 1'b1;
        repeat (2 * HP) @(negedge CLK);
        host_dat_low = 1'b1;
        repeat (2) @(negedge CLK);
        host_clk_low = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 10 && ok; k++) begin
            wait_fall(ok, n);
            host_dat_low = ~bits[k];
        end
        if (ok) wait_rise(ok);
        repeat (3) @(negedge CLK);
        host_dat_low = 1'b0;
        if (ok && stop) begin
            wait_fall(ok, n);
            repeat (2) @(negedge CLK);
            check("ack_bit_low", 32'(ps2dat), 0);
            wait_rise(ok);
        end
        host_busy = 1'b0;
    endtask

    task automatic expect_cmd(input logic [7:0] b, input logic par, input logic stop);
        logic good;
        if (!stop) begin
            rxq.push_back('{1'b1, last_rx});
            txq.push_back(8'hFE);
        end else begin
            good = ^{par, b};
            last_rx = b;
            rxq.push_back('{!good, b});
            txq.push_back(good ? 8'hFA : 8'hFE);
        end
    endtask

    initial begin
        logic ok, held, stop, par;
        logic [7:0] b;
        int fr, n, cnt, base;

        repeat (3) @(negedge CLK);
        check("reset_ctrl_outputs", {27'd0, TX_READY, RX_VALID, RX_ERR, PS2CLK_OE, PS2DATA_OE}, 0);
        check("reset_rx_data", 32'(RX_DATA), 0);
        RST = 1'b1;
        wait_idle();

        // Plain transmit of 0x1C, then busy window from accept to end of holdoff.
        txq.push_back(8'h1C);
        tx_offer(8'h1C, ok, fr);
        cnt = 0;
        @(negedge CLK);
        while (!TX_READY && cnt < 500) begin cnt++; @(negedge CLK); end
        check("tx_busy_cycles", cnt, 23 * HP);
        wait_idle();

        // Good command 0xED, then the same with bad parity.
        expect_cmd(8'hED, 1'b1, 1'b1);
        host_cmd(8'hED, 1'b1, 1'b1);
        wait_idle();
        expect_cmd(8'hED, 1'b0, 1'b1);
        host_cmd(8'hED, 1'b0, 1'b1);
        wait_idle();

        // Host inhibits during the D4 high phase of 0xAA; whole frame is resent.
        txq.push_back(8'hAA);
        tx_offer(8'hAA, ok, fr);
        for (int k = 0; k < 5; k++) wait_fall(ok, n);
        wait_rise(ok);
        check("d4_data_driven", 32'(PS2DATA_OE), 1);
        host_clk_low = 1'b1;
        repeat (HP) @(negedge CLK);
        check("abort_release", {30'd0, PS2CLK_OE, PS2DATA_OE}, 0);
        held = 1'b0;
        repeat (3 * HP) begin
            @(negedge CLK);
            held = held | PS2CLK_OE | PS2DATA_OE;
        end
        check("stay_released", 32'(held), 0);
        host_clk_low = 1'b0;
        wait_fall(ok, n);
        check("restart_delay_ok", 32'(n >= 3 * HP && n <= 3 * HP + 4), 1);
        wait_idle();

        // RTS together with TX_VALID: command and its response go first.
        expect_cmd(8'h3C, ~^8'h3C, 1'b1);
        txq.push_back(8'h5A);
        base = frames_done;
        fork
            host_cmd(8'h3C, ~^8'h3C, 1'b1);
            begin
                repeat (4) @(negedge CLK);
                tx_offer(8'h5A, ok, fr);
            end
        join
        check("accept_after_response", fr, base + 1);
        wait_idle();

        // Randomized mix of device bytes and host commands.
        for (int t = 0; t < 14; t++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                txq.push_back(b);
                tx_offer(b, ok, fr);
            end else begin
                par  = ~^b ^ ($urandom_range(0, 3) == 0);
                stop = ($urandom_range(0, 5) != 0);
                expect_cmd(b, par, stop);
                host_cmd(b, par, stop);
            end
            wait_idle();
        end

        // Reset in the middle of a transmit; nothing may be resent.
        txq.push_back(8'h96);
        tx_offer(8'h96, ok, fr);
        for (int k = 0; k < 7; k++) wait_fall(ok, n);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("reset_mid_tx_oe", {30'd0, PS2CLK_OE, PS2DATA_OE}, 0);
        txq.delete();
        rxq.delete();
        last_rx = '0;
        base = frames_done;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (6) @(negedge CLK);
        check("ready_after_reset", 32'(TX_READY), 1);
        repeat (30 * HP) @(negedge CLK);
        check("no_resend", frames_done, base);
        check("rx_data_cleared", 32'(RX_DATA), 0);

        check("txq_drained", txq.size(), 0);
        check("rxq_drained", rxq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
